// File: rtl/fir_filter_if.sv
// Sample-path bundle for the parallel FIR filter:
// input sample, tap coefficients and registered output.
interface fir_filter_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int FILTER_LENGTH     = 71
);
  localparam int OW = DATA_WIDTH + COEFFICIENT_WIDTH;

  logic signed [DATA_WIDTH-1:0]        i_sig;
  logic signed [COEFFICIENT_WIDTH-1:0] coefficients [FILTER_LENGTH];
  logic signed [OW-1:0]                o_sig;

  modport master (
    output i_sig,
    output coefficients,
    input  o_sig
  );

  modport slave (
    input  i_sig,
    input  coefficients,
    output o_sig
  );
endinterface

// File: rtl/fir_filter.sv
// Direct-form fully parallel FIR: one sample in, one
// saturated filtered sample out per clock.
module fir_filter #(
  parameter int DATA_WIDTH        = 16,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int FILTER_LENGTH     = 71
) (
  input logic         clk,
  input logic         rst,
  fir_filter_if.slave bus
);
  localparam int W  = DATA_WIDTH + COEFFICIENT_WIDTH;
  localparam int AW = W + $clog2(FILTER_LENGTH);
  localparam int GW = AW - W + 1;

  localparam logic signed [W-1:0] MAXV =
    {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV =
    {1'b1, {(W-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] x_reg [FILTER_LENGTH];
  logic signed [W-1:0]          prod  [FILTER_LENGTH];
  logic signed [AW-1:0]         acc;
  logic        [GW-1:0]         top;
  logic                         ovf;
  logic signed [W-1:0]          sat;
  logic signed [W-1:0]          o_q;

  always_comb begin
    for (int k = 0; k < FILTER_LENGTH; k++) begin
      prod[k] = W'(bus.coefficients[k]) * W'(x_reg[k]);
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < FILTER_LENGTH; k++) begin
      acc = acc + AW'(prod[k]);
    end
  end

  // Overflow when the guard bits disagree with the sign.
  assign top = acc[AW-1:W-1];
  assign ovf = top != {GW{acc[AW-1]}};

  always_comb begin
    sat = acc[W-1:0];
    if (ovf) begin
      sat = acc[AW-1] ? MINV : MAXV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FILTER_LENGTH; k++) begin
        x_reg[k] <= '0;
      end
      o_q <= '0;
    end else begin
      x_reg[0] <= bus.i_sig;
      for (int k = 1; k < FILTER_LENGTH; k++) begin
        x_reg[k] <= x_reg[k-1];
      end
      o_q <= sat;
    end
  end

  assign bus.o_sig = o_q;
endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: driver pushes expected outputs,
// monitor pops and compares after every clock edge.
module tb_fir_filter;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int L  = 71;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct {
    longint exp;
    string  tag;
  } ent_t;

  logic clk;
  logic rst;
  ent_t q[$];
  int   total;
  int   bad;
  int   cf [L];
  int   cimp [L];
  longint h [L];

  fir_filter_if #(
    .DATA_WIDTH(DW),
    .COEFFICIENT_WIDTH(CW),
    .FILTER_LENGTH(L)
  ) bus ();

  fir_filter #(
    .DATA_WIDTH(DW),
    .COEFFICIENT_WIDTH(CW),
    .FILTER_LENGTH(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint clamp(input longint a);
    if (a > MAXV) return MAXV;
    if (a < MINV) return MINV;
    return a;
  endfunction

  function automatic longint model();
    longint s;
    s = 0;
    for (int k = 0; k < L; k++) begin
      s += longint'(cf[k]) * h[k];
    end
    return clamp(s);
  endfunction

  task automatic cyc(input logic r, input int x,
                     input bit hv, input longint hval,
                     input string tag);
    ent_t e;
    @(negedge clk);
    rst = r;
    bus.i_sig = DW'(x);
    for (int k = 0; k < L; k++) begin
      bus.coefficients[k] = CW'(cf[k]);
    end
    if (r) begin
      e.exp = 0;
      for (int k = 0; k < L; k++) h[k] = 0;
    end else begin
      e.exp = model();
      for (int k = L - 1; k > 0; k--) h[k] = h[k-1];
      h[0] = longint'(x);
    end
    if (hv) e.exp = hval;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic impulse(input string tag);
    cyc(1'b0, 1, 1'b1, 0, tag);
    for (int j = 1; j <= L; j++) begin
      cyc(1'b0, 0, 1'b1, longint'(cimp[j-1]), tag);
    end
    cyc(1'b0, 0, 1'b1, 0, tag);
    cyc(1'b0, 0, 1'b1, 0, tag);
  endtask

  initial begin : monitor
    ent_t e;
    longint got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        got = longint'($signed(bus.o_sig));
        total++;
        if (got != e.exp) begin
          bad++;
          $display("FAIL %s: o_sig=%0d expected=%0d",
                   e.tag, got, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: run did not end, bad=%0d", bad);
    $fatal(1);
  end

  initial begin : driver
    logic signed [CW-1:0] rc;
    logic signed [DW-1:0] rx;
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.i_sig = '0;
    for (int k = 0; k < L; k++) begin
      bus.coefficients[k] = '0;
      cimp[k] = ((k * 977) % 6001) - 3000;
      cf[k] = cimp[k];
      h[k] = 0;
    end

    // reset state, i_sig ignored during reset
    cyc(1'b1, 1234, 1'b1, 0, "reset");
    cyc(1'b1, -99, 1'b1, 0, "reset");

    impulse("impulse");

    // step response
    for (int k = 0; k < L; k++) cf[k] = 1;
    cyc(1'b1, 0, 1'b1, 0, "step_rst");
    for (int j = 0; j < 90; j++) begin
      cyc(1'b0, 100, 1'b1,
          100 * longint'(j < L ? j : L), "step");
    end

    // negative saturation
    for (int k = 0; k < L; k++) cf[k] = 32767;
    cyc(1'b1, 0, 1'b1, 0, "satn_rst");
    for (int j = 0; j < 80; j++) begin
      cyc(1'b0, -32768, 1'b1,
          clamp(longint'(j < L ? j : L) * -64'sd1073709056),
          "sat_neg");
    end

    // positive saturation
    for (int k = 0; k < L; k++) cf[k] = -32768;
    cyc(1'b1, 0, 1'b1, 0, "satp_rst");
    for (int j = 0; j < 80; j++) begin
      cyc(1'b0, -32768, 1'b1,
          clamp(longint'(j < L ? j : L) * 64'sd1073741824),
          "sat_pos");
    end

    // reset mid-stream, then held, then clean impulse
    for (int k = 0; k < L; k++) cf[k] = cimp[k];
    cyc(1'b1, 0, 1'b1, 0, "mid_rst0");
    for (int j = 0; j < 30; j++) begin
      cyc(1'b0, 500, 1'b0, 0, "mid_stream");
    end
    cyc(1'b1, 500, 1'b1, 0, "mid_rst");
    impulse("post_rst_imp");
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 777, 1'b1, 0, "rst_hold");
    end
    cyc(1'b0, 1, 1'b1, 0, "hold_imp0");
    cyc(1'b0, 0, 1'b1, longint'(cimp[0]), "hold_imp1");

    // signed taps with alternating input
    for (int k = 0; k < L; k++) cf[k] = k - 35;
    cyc(1'b1, 0, 1'b1, 0, "mixed_rst");
    for (int j = 0; j < 160; j++) begin
      cyc(1'b0, (j % 2 == 0) ? 1000 : -1000,
          1'b0, 0, "mixed");
    end

    // random coefficients and samples
    for (int k = 0; k < L; k++) begin
      rc = CW'($urandom);
      cf[k] = int'(rc);
    end
    cyc(1'b1, 0, 1'b1, 0, "rand_rst");
    for (int j = 0; j < 2000; j++) begin
      rx = DW'($urandom);
      cyc(1'b0, int'(rx), 1'b0, 0, "random");
    end

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
